// File: rtl/decode_scoreboard_if.sv
// Signal bundle between fetch/writeback and the decode scoreboard.
// The master side drives every I_* signal and the slave side (the decode stage) drives every O_* signal.
interface decode_scoreboard_if #(
  parameter int REG_WIDTH = 16,
  parameter int NUM_RF    = 16,
  parameter int NUM_WB    = 2,
  parameter int PC_WIDTH  = 16,
  parameter int IR_WIDTH  = 32
);
  localparam int RIDX = $clog2(NUM_RF);

  logic                        I_LOCK;
  logic                        I_FE_Valid;
  logic [PC_WIDTH-1:0]         I_PC;
  logic [IR_WIDTH-1:0]         I_IR;
  logic [RIDX-1:0]             I_Src1Idx;
  logic [RIDX-1:0]             I_Src2Idx;
  logic [RIDX-1:0]             I_DestIdx;
  logic                        I_Src1Use;
  logic                        I_Src2Use;
  logic                        I_DestWrite;
  logic                        I_CCRead;
  logic                        I_CCWrite;
  logic                        I_IsBranch;
  logic [NUM_WB-1:0]           I_RegWEn;
  logic [NUM_WB*RIDX-1:0]      I_WriteBackRegIdx;
  logic [NUM_WB*REG_WIDTH-1:0] I_WriteBackData;
  logic                        I_CCWEn;
  logic [2:0]                  I_CCValue;
  logic                        I_WriteBackPCEn;
  logic                        I_GPUStallSignal;

  logic                        O_DE_Valid;
  logic [PC_WIDTH-1:0]         O_PC;
  logic [IR_WIDTH-1:0]         O_IR;
  logic [REG_WIDTH-1:0]        O_Src1Value;
  logic [REG_WIDTH-1:0]        O_Src2Value;
  logic [RIDX-1:0]             O_DestRegIdx;
  logic [2:0]                  O_CCValue;
  logic                        O_DepStallSignal;
  logic                        O_BranchStallSignal;

  modport master (
    output I_LOCK, I_FE_Valid, I_PC, I_IR, I_Src1Idx, I_Src2Idx, I_DestIdx,
           I_Src1Use, I_Src2Use, I_DestWrite, I_CCRead, I_CCWrite, I_IsBranch,
           I_RegWEn, I_WriteBackRegIdx, I_WriteBackData, I_CCWEn, I_CCValue,
           I_WriteBackPCEn, I_GPUStallSignal,
    input  O_DE_Valid, O_PC, O_IR, O_Src1Value, O_Src2Value, O_DestRegIdx,
           O_CCValue, O_DepStallSignal, O_BranchStallSignal
  );

  modport slave (
    input  I_LOCK, I_FE_Valid, I_PC, I_IR, I_Src1Idx, I_Src2Idx, I_DestIdx,
           I_Src1Use, I_Src2Use, I_DestWrite, I_CCRead, I_CCWrite, I_IsBranch,
           I_RegWEn, I_WriteBackRegIdx, I_WriteBackData, I_CCWEn, I_CCValue,
           I_WriteBackPCEn, I_GPUStallSignal,
    output O_DE_Valid, O_PC, O_IR, O_Src1Value, O_Src2Value, O_DestRegIdx,
           O_CCValue, O_DepStallSignal, O_BranchStallSignal
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Decode/register-read stage: counter-based pending-write scoreboard, multi-port
// writeback with same-cycle forwarding, and a branch-resolution hold FSM.
module decode_scoreboard #(
  parameter int REG_WIDTH  = 16,
  parameter int NUM_RF     = 16,
  parameter int NUM_WB     = 2,
  parameter int PEND_WIDTH = 2,
  parameter int PC_WIDTH   = 16,
  parameter int IR_WIDTH   = 32
) (
  input  logic               I_CLOCK,
  input  logic               I_RESET_N,
  decode_scoreboard_if.slave bus
);
  localparam int RIDX = $clog2(NUM_RF);
  localparam int HW   = $clog2(NUM_WB + 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  typedef enum logic [0:0] {IDLE, BR_WAIT} state_t;

  state_t                state_q;
  logic [REG_WIDTH-1:0]  rf_q      [NUM_RF];
  logic [PEND_WIDTH-1:0] pendCnt_q [NUM_RF];
  logic [PEND_WIDTH-1:0] pendCnt_d [NUM_RF];
  logic [PEND_WIDTH-1:0] effCnt    [NUM_RF];
  logic [HW-1:0]         hitCnt    [NUM_RF];
  logic [PEND_WIDTH-1:0] ccCnt_q, ccCnt_d, ccEff;
  logic [2:0]            cc_q, ccFwd;
  logic [REG_WIDTH-1:0]  src1Fwd, src2Fwd;
  logic                  src1Pend, src2Pend, ccPend, wawStall, dep, accept;

  logic                  deValid_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [IR_WIDTH-1:0]   ir_q;
  logic [REG_WIDTH-1:0]  src1_q, src2_q;
  logic [RIDX-1:0]       destIdx_q;
  logic [2:0]            ccOut_q;

  // A decrement that would take a counter below zero is dropped, so eff saturates at 0.
  always_comb begin
    for (int r = 0; r < NUM_RF; r++) begin
      hitCnt[r] = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (bus.I_RegWEn[p] && (bus.I_WriteBackRegIdx[p*RIDX +: RIDX] == RIDX'(r)))
          hitCnt[r] = hitCnt[r] + HW'(1);
      end
      if (int'(hitCnt[r]) >= int'(pendCnt_q[r]))
        effCnt[r] = '0;
      else
        effCnt[r] = pendCnt_q[r] - PEND_WIDTH'(hitCnt[r]);
    end
  end

  // Ascending port order lets the highest-index writer win the forwarded value.
  always_comb begin
    src1Fwd = rf_q[bus.I_Src1Idx];
    src2Fwd = rf_q[bus.I_Src2Idx];
    for (int p = 0; p < NUM_WB; p++) begin
      if (bus.I_RegWEn[p] && (bus.I_WriteBackRegIdx[p*RIDX +: RIDX] == bus.I_Src1Idx))
        src1Fwd = bus.I_WriteBackData[p*REG_WIDTH +: REG_WIDTH];
      if (bus.I_RegWEn[p] && (bus.I_WriteBackRegIdx[p*RIDX +: RIDX] == bus.I_Src2Idx))
        src2Fwd = bus.I_WriteBackData[p*REG_WIDTH +: REG_WIDTH];
    end
  end

  assign ccEff    = (bus.I_CCWEn && (ccCnt_q != '0)) ? ccCnt_q - PEND_WIDTH'(1) : ccCnt_q;
  assign ccFwd    = bus.I_CCWEn ? bus.I_CCValue : cc_q;
  assign src1Pend = bus.I_Src1Use && (effCnt[bus.I_Src1Idx] != '0);
  assign src2Pend = bus.I_Src2Use && (effCnt[bus.I_Src2Idx] != '0);
  assign ccPend   = bus.I_CCRead && (ccEff != '0);
  assign wawStall = (bus.I_DestWrite && (effCnt[bus.I_DestIdx] == PEND_MAX)) ||
                    (bus.I_CCWrite && (ccEff == PEND_MAX));
  assign dep      = bus.I_FE_Valid && (src1Pend || src2Pend || ccPend || wawStall);
  assign accept   = bus.I_FE_Valid && bus.I_LOCK && !bus.I_GPUStallSignal && !dep &&
                    (state_q == IDLE);

  always_comb begin
    for (int r = 0; r < NUM_RF; r++) begin
      pendCnt_d[r] = effCnt[r];
      if (accept && bus.I_DestWrite && (bus.I_DestIdx == RIDX'(r)))
        pendCnt_d[r] = effCnt[r] + PEND_WIDTH'(1);
    end
    ccCnt_d = ccEff;
    if (accept && bus.I_CCWrite)
      ccCnt_d = ccEff + PEND_WIDTH'(1);
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int r = 0; r < NUM_RF; r++) begin
        rf_q[r]      <= '0;
        pendCnt_q[r] <= '0;
      end
      ccCnt_q <= '0;
      cc_q    <= '0;
    end else begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (bus.I_RegWEn[p])
          rf_q[bus.I_WriteBackRegIdx[p*RIDX +: RIDX]] <= bus.I_WriteBackData[p*REG_WIDTH +: REG_WIDTH];
      end
      for (int r = 0; r < NUM_RF; r++)
        pendCnt_q[r] <= pendCnt_d[r];
      ccCnt_q <= ccCnt_d;
      if (bus.I_CCWEn)
        cc_q <= bus.I_CCValue;
    end
  end

  // A GPU stall freezes the whole issue register, valid included.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q   <= IDLE;
      deValid_q <= 1'b0;
      pc_q      <= '0;
      ir_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      destIdx_q <= '0;
      ccOut_q   <= '0;
    end else begin
      case (state_q)
        IDLE:    if (accept && bus.I_IsBranch) state_q <= BR_WAIT;
        BR_WAIT: if (bus.I_WriteBackPCEn) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (accept) begin
        deValid_q <= 1'b1;
        pc_q      <= bus.I_PC;
        ir_q      <= bus.I_IR;
        src1_q    <= src1Fwd;
        src2_q    <= src2Fwd;
        destIdx_q <= bus.I_DestIdx;
        ccOut_q   <= ccFwd;
      end else if (!bus.I_GPUStallSignal) begin
        deValid_q <= 1'b0;
      end
    end
  end

  assign bus.O_DE_Valid          = deValid_q;
  assign bus.O_PC                = pc_q;
  assign bus.O_IR                = ir_q;
  assign bus.O_Src1Value         = src1_q;
  assign bus.O_Src2Value         = src2_q;
  assign bus.O_DestRegIdx        = destIdx_q;
  assign bus.O_CCValue           = ccOut_q;
  assign bus.O_DepStallSignal    = dep;
  assign bus.O_BranchStallSignal = bus.I_FE_Valid && ((state_q == BR_WAIT) || bus.I_IsBranch);
endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: directed scenarios plus randomized
// traffic compared against a per-register pending-count reference model.
module tb_decode_scoreboard;
  localparam int REG_WIDTH  = 16;
  localparam int NUM_RF     = 16;
  localparam int NUM_WB     = 2;
  localparam int PEND_WIDTH = 2;
  localparam int PC_WIDTH   = 16;
  localparam int IR_WIDTH   = 32;
  localparam int RIDX       = 4;
  localparam int MAXP       = 3;

  logic I_CLOCK;
  logic I_RESET_N;

  decode_scoreboard_if #(.REG_WIDTH(REG_WIDTH), .NUM_RF(NUM_RF), .NUM_WB(NUM_WB),
                         .PC_WIDTH(PC_WIDTH), .IR_WIDTH(IR_WIDTH)) bus ();

  decode_scoreboard #(.REG_WIDTH(REG_WIDTH), .NUM_RF(NUM_RF), .NUM_WB(NUM_WB),
                      .PEND_WIDTH(PEND_WIDTH), .PC_WIDTH(PC_WIDTH), .IR_WIDTH(IR_WIDTH))
    dut (.I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding writes per register, architectural state, issue view.
  int                   pend [NUM_RF];
  int                   ccPendM;
  logic [REG_WIDTH-1:0] rfM  [NUM_RF];
  logic [2:0]           ccM;
  bit                   inBranch;
  logic                 eValid;
  logic [PC_WIDTH-1:0]  ePC;
  logic [IR_WIDTH-1:0]  eIR;
  logic [REG_WIDTH-1:0] eS1, eS2;
  logic [RIDX-1:0]      eDest;
  logic [2:0]           eCC;
  logic                 expDep, expBr, obsDep, obsBr;

  initial begin
    I_CLOCK = 1'b0;
    forever #5 I_CLOCK = ~I_CLOCK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic modelReset();
    for (int r = 0; r < NUM_RF; r++) begin
      pend[r] = 0;
      rfM[r]  = '0;
    end
    ccPendM = 0; ccM = '0; inBranch = 0;
    eValid = 0; ePC = '0; eIR = '0; eS1 = '0; eS2 = '0; eDest = '0; eCC = '0;
  endtask

  task automatic modelStep();
    int hits [NUM_RF];
    int effv [NUM_RF];
    logic [REG_WIDTH-1:0] post [NUM_RF];
    int ccEffv;
    bit acc;
    for (int r = 0; r < NUM_RF; r++) begin
      hits[r] = 0;
      post[r] = rfM[r];
    end
    for (int p = 0; p < NUM_WB; p++) begin
      if (bus.I_RegWEn[p]) begin
        hits[bus.I_WriteBackRegIdx[p*RIDX +: RIDX]]++;
        post[bus.I_WriteBackRegIdx[p*RIDX +: RIDX]] = bus.I_WriteBackData[p*REG_WIDTH +: REG_WIDTH];
      end
    end
    for (int r = 0; r < NUM_RF; r++) begin
      if (hits[r] > pend[r]) $display("[TB] note: writeback below zero on r%0d", r);
      effv[r] = (hits[r] > pend[r]) ? 0 : pend[r] - hits[r];
    end
    ccEffv = (bus.I_CCWEn && ccPendM > 0) ? ccPendM - 1 : ccPendM;
    expDep = bus.I_FE_Valid && ((bus.I_Src1Use && effv[bus.I_Src1Idx] != 0) ||
                                (bus.I_Src2Use && effv[bus.I_Src2Idx] != 0) ||
                                (bus.I_CCRead && ccEffv != 0) ||
                                (bus.I_DestWrite && effv[bus.I_DestIdx] == MAXP) ||
                                (bus.I_CCWrite && ccEffv == MAXP));
    expBr = bus.I_FE_Valid && (inBranch || bus.I_IsBranch);
    acc = bus.I_FE_Valid && bus.I_LOCK && !bus.I_GPUStallSignal && !expDep && !inBranch;
    if (acc) begin
      eValid = 1; ePC = bus.I_PC; eIR = bus.I_IR;
      eS1 = post[bus.I_Src1Idx]; eS2 = post[bus.I_Src2Idx]; eDest = bus.I_DestIdx;
      eCC = bus.I_CCWEn ? bus.I_CCValue : ccM;
    end else if (!bus.I_GPUStallSignal) begin
      eValid = 0;
    end
    for (int r = 0; r < NUM_RF; r++) begin
      pend[r] = effv[r];
      rfM[r]  = post[r];
    end
    if (acc && bus.I_DestWrite) pend[bus.I_DestIdx]++;
    ccPendM = ccEffv + ((acc && bus.I_CCWrite) ? 1 : 0);
    if (bus.I_CCWEn) ccM = bus.I_CCValue;
    if (inBranch) begin
      if (bus.I_WriteBackPCEn) inBranch = 0;
    end else if (acc && bus.I_IsBranch) begin
      inBranch = 1;
    end
  endtask

  // Sample combinational stalls mid-cycle, advance the model, then land 1ns past the edge.
  task automatic tick();
    #2;
    obsDep = bus.O_DepStallSignal;
    obsBr  = bus.O_BranchStallSignal;
    modelStep();
    @(posedge I_CLOCK);
    #1;
  endtask

  task automatic clearWb();
    bus.I_RegWEn = '0; bus.I_WriteBackRegIdx = '0; bus.I_WriteBackData = '0;
    bus.I_CCWEn = 0; bus.I_CCValue = '0; bus.I_WriteBackPCEn = 0;
  endtask

  task automatic idleFe();
    bus.I_FE_Valid = 0; bus.I_PC = '0; bus.I_IR = '0;
    bus.I_Src1Idx = '0; bus.I_Src2Idx = '0; bus.I_DestIdx = '0;
    bus.I_Src1Use = 0; bus.I_Src2Use = 0; bus.I_DestWrite = 0;
    bus.I_CCRead = 0; bus.I_CCWrite = 0; bus.I_IsBranch = 0;
  endtask

  task automatic issue(input int s1, input bit u1, input int s2, input bit u2,
                       input int d, input bit dw, input bit br);
    bus.I_FE_Valid = 1; bus.I_LOCK = 1;
    bus.I_PC = PC_WIDTH'($urandom); bus.I_IR = $urandom;
    bus.I_Src1Idx = RIDX'(s1); bus.I_Src1Use = u1;
    bus.I_Src2Idx = RIDX'(s2); bus.I_Src2Use = u2;
    bus.I_DestIdx = RIDX'(d);  bus.I_DestWrite = dw;
    bus.I_CCRead = 0; bus.I_CCWrite = 0; bus.I_IsBranch = br;
  endtask

  task automatic wb(input int port, input int idx, input logic [REG_WIDTH-1:0] data);
    bus.I_RegWEn[port] = 1'b1;
    bus.I_WriteBackRegIdx[port*RIDX +: RIDX] = RIDX'(idx);
    bus.I_WriteBackData[port*REG_WIDTH +: REG_WIDTH] = data;
  endtask

  task automatic drainAll();
    idleFe();
    for (int guard = 0; guard < 64; guard++) begin
      bit found;
      clearWb();
      found = 0;
      for (int r = 0; r < NUM_RF; r++) begin
        if (pend[r] > 0 && !found) begin
          wb(0, r, REG_WIDTH'($urandom));
          found = 1;
        end
      end
      if (ccPendM > 0) begin
        bus.I_CCWEn = 1;
        bus.I_CCValue = 3'($urandom);
      end
      if (inBranch) bus.I_WriteBackPCEn = 1;
      if (!found && ccPendM == 0 && !inBranch) break;
      tick();
    end
    clearWb();
  endtask

  task automatic test_reset();
    logic [PC_WIDTH+IR_WIDTH+2*REG_WIDTH+RIDX+3:0] allOut;
    I_RESET_N = 0;
    bus.I_LOCK = 0; bus.I_GPUStallSignal = 0;
    idleFe(); clearWb(); modelReset();
    repeat (2) @(posedge I_CLOCK);
    #1;
    allOut = {bus.O_DE_Valid, bus.O_PC, bus.O_IR, bus.O_Src1Value, bus.O_Src2Value,
              bus.O_DestRegIdx, bus.O_CCValue};
    total++;
    if (allOut !== '0) begin bad++; $display("[TB] FAIL reset_outputs got=%h want=0", allOut); end
    I_RESET_N = 1;

    issue(0, 0, 0, 0, 3, 1, 0); tick();
    issue(0, 0, 0, 0, 3, 1, 0); tick();
    issue(3, 1, 0, 0, 0, 0, 0);
    #2;
    total++;
    if (bus.O_DepStallSignal !== 1'b1) begin bad++; $display("[TB] FAIL reset_pre_stall got=%b want=1", bus.O_DepStallSignal); end
    #1 I_RESET_N = 0;
    #1;
    allOut = {bus.O_DE_Valid, bus.O_PC, bus.O_IR, bus.O_Src1Value, bus.O_Src2Value,
              bus.O_DestRegIdx, bus.O_CCValue};
    total++;
    if (allOut !== '0) begin bad++; $display("[TB] FAIL reset_async_outputs got=%h want=0", allOut); end
    total++;
    if (bus.O_DepStallSignal !== 1'b0) begin bad++; $display("[TB] FAIL reset_async_stall got=%b want=0", bus.O_DepStallSignal); end
    modelReset();
    I_RESET_N = 1;
    tick();
    total++;
    if (obsDep !== 1'b0) begin bad++; $display("[TB] FAIL reset_reader_stall got=%b want=0", obsDep); end
    total++;
    if (bus.O_DE_Valid !== 1'b1) begin bad++; $display("[TB] FAIL reset_reader_valid got=%b want=1", bus.O_DE_Valid); end
    idleFe();
  endtask

  task automatic test_raw_forward();
    issue(0, 0, 0, 0, 5, 1, 0); tick();
    total++;
    if (bus.O_DestRegIdx !== 4'd5) begin bad++; $display("[TB] FAIL raw_dest got=%0d want=5", bus.O_DestRegIdx); end
    issue(5, 1, 0, 0, 0, 0, 0);
    repeat (2) begin
      tick();
      total++;
      if (obsDep !== 1'b1 || bus.O_DE_Valid !== 1'b0) begin
        bad++; $display("[TB] FAIL raw_stall got=dep%b/v%b want=dep1/v0", obsDep, bus.O_DE_Valid);
      end
    end
    wb(0, 5, 16'h1234);
    tick();
    clearWb();
    total++;
    if (obsDep !== 1'b0) begin bad++; $display("[TB] FAIL raw_release got=%b want=0", obsDep); end
    total++;
    if (bus.O_DE_Valid !== 1'b1 || bus.O_Src1Value !== 16'h1234) begin
      bad++; $display("[TB] FAIL raw_forward got=v%b/%h want=v1/1234", bus.O_DE_Valid, bus.O_Src1Value);
    end
    idleFe();
  endtask

  task automatic test_dual_wb();
    issue(0, 0, 0, 0, 2, 1, 0); tick();
    issue(0, 0, 0, 0, 2, 1, 0); tick();
    idleFe();
    wb(0, 2, 16'hAAAA);
    wb(1, 2, 16'hBBBB);
    tick();
    clearWb();
    issue(2, 1, 2, 1, 0, 0, 0);
    tick();
    total++;
    if (obsDep !== 1'b0) begin bad++; $display("[TB] FAIL dual_cnt_clear got=%b want=0", obsDep); end
    total++;
    if (bus.O_Src1Value !== 16'hBBBB || bus.O_Src2Value !== 16'hBBBB) begin
      bad++; $display("[TB] FAIL dual_data got=%h/%h want=bbbb", bus.O_Src1Value, bus.O_Src2Value);
    end
    idleFe();
  endtask

  task automatic test_waw_sat();
    for (int k = 0; k < 3; k++) begin
      issue(0, 0, 0, 0, 7, 1, 0);
      tick();
      total++;
      if (bus.O_DE_Valid !== 1'b1) begin bad++; $display("[TB] FAIL waw_fill%0d got=%b want=1", k, bus.O_DE_Valid); end
    end
    issue(0, 0, 0, 0, 7, 1, 0);
    tick();
    total++;
    if (obsDep !== 1'b1 || bus.O_DE_Valid !== 1'b0) begin
      bad++; $display("[TB] FAIL waw_fourth_stall got=dep%b/v%b want=dep1/v0", obsDep, bus.O_DE_Valid);
    end
    wb(0, 7, 16'h0707);
    tick();
    clearWb();
    total++;
    if (obsDep !== 1'b0 || bus.O_DE_Valid !== 1'b1 || bus.O_DestRegIdx !== 4'd7) begin
      bad++; $display("[TB] FAIL waw_release got=dep%b/v%b/d%0d want=dep0/v1/d7", obsDep, bus.O_DE_Valid, bus.O_DestRegIdx);
    end
    issue(0, 0, 0, 0, 7, 1, 0);
    tick();
    total++;
    if (obsDep !== 1'b1) begin bad++; $display("[TB] FAIL waw_still_full got=%b want=1", obsDep); end
    drainAll();
  endtask

  task automatic test_branch();
    issue(0, 0, 0, 0, 0, 0, 1);
    tick();
    total++;
    if (obsBr !== 1'b1 || bus.O_DE_Valid !== 1'b1) begin
      bad++; $display("[TB] FAIL br_accept got=br%b/v%b want=br1/v1", obsBr, bus.O_DE_Valid);
    end
    issue(1, 0, 2, 0, 4, 1, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (obsBr !== 1'b1 || bus.O_DE_Valid !== 1'b0) begin
        bad++; $display("[TB] FAIL br_hold%0d got=br%b/v%b want=br1/v0", k, obsBr, bus.O_DE_Valid);
      end
    end
    idleFe();
    tick();
    total++;
    if (obsBr !== 1'b0) begin bad++; $display("[TB] FAIL br_fe_idle got=%b want=0", obsBr); end
    issue(1, 0, 2, 0, 4, 1, 0);
    bus.I_WriteBackPCEn = 1;
    tick();
    total++;
    if (obsBr !== 1'b1 || bus.O_DE_Valid !== 1'b0) begin
      bad++; $display("[TB] FAIL br_resolve_edge got=br%b/v%b want=br1/v0", obsBr, bus.O_DE_Valid);
    end
    bus.I_WriteBackPCEn = 0;
    tick();
    total++;
    if (obsBr !== 1'b0 || bus.O_DE_Valid !== 1'b1 || bus.O_DestRegIdx !== 4'd4) begin
      bad++; $display("[TB] FAIL br_next_accept got=br%b/v%b/d%0d want=br0/v1/d4", obsBr, bus.O_DE_Valid, bus.O_DestRegIdx);
    end
    drainAll();
  endtask

  task automatic test_gpu_stall();
    logic [PC_WIDTH-1:0] heldPC;
    issue(0, 0, 0, 0, 9, 1, 0);
    heldPC = bus.I_PC;
    tick();
    total++;
    if (bus.O_DE_Valid !== 1'b1 || bus.O_DestRegIdx !== 4'd9) begin
      bad++; $display("[TB] FAIL gpu_setup got=v%b/d%0d want=v1/d9", bus.O_DE_Valid, bus.O_DestRegIdx);
    end
    issue(0, 0, 0, 0, 10, 1, 0);
    bus.I_GPUStallSignal = 1;
    wb(0, 9, 16'h0F0F);
    for (int k = 0; k < 3; k++) begin
      tick();
      clearWb();
      total++;
      if (bus.O_DE_Valid !== 1'b1 || bus.O_DestRegIdx !== 4'd9 || bus.O_PC !== heldPC) begin
        bad++; $display("[TB] FAIL gpu_hold%0d got=v%b/d%0d/pc%h want=v1/d9/pc%h", k, bus.O_DE_Valid, bus.O_DestRegIdx, bus.O_PC, heldPC);
      end
    end
    bus.I_GPUStallSignal = 0;
    issue(9, 1, 10, 1, 0, 0, 0);
    tick();
    total++;
    if (obsDep !== 1'b0 || bus.O_DE_Valid !== 1'b1) begin
      bad++; $display("[TB] FAIL gpu_counters got=dep%b/v%b want=dep0/v1", obsDep, bus.O_DE_Valid);
    end
    total++;
    if (bus.O_Src1Value !== 16'h0F0F) begin bad++; $display("[TB] FAIL gpu_wb_data got=%h want=0f0f", bus.O_Src1Value); end
    idleFe();
  endtask

  task automatic test_random();
    int avail [NUM_RF];
    for (int c = 0; c < 600; c++) begin
      clearWb();
      bus.I_FE_Valid = ($urandom_range(0, 3) != 0);
      bus.I_LOCK = ($urandom_range(0, 9) != 0);
      bus.I_GPUStallSignal = ($urandom_range(0, 6) == 0);
      bus.I_PC = PC_WIDTH'($urandom); bus.I_IR = $urandom;
      bus.I_Src1Idx = RIDX'($urandom_range(0, 7)); bus.I_Src1Use = 1'($urandom);
      bus.I_Src2Idx = RIDX'($urandom_range(0, 7)); bus.I_Src2Use = 1'($urandom);
      bus.I_DestIdx = RIDX'($urandom_range(0, 7)); bus.I_DestWrite = 1'($urandom);
      bus.I_CCRead = ($urandom_range(0, 3) == 0);
      bus.I_CCWrite = ($urandom_range(0, 3) == 0);
      bus.I_IsBranch = ($urandom_range(0, 19) == 0);
      for (int r = 0; r < NUM_RF; r++) avail[r] = pend[r];
      for (int p = 0; p < NUM_WB; p++) begin
        if ($urandom_range(0, 9) < 5) begin
          int start;
          bit found;
          start = $urandom_range(0, NUM_RF - 1);
          found = 0;
          for (int k = 0; k < NUM_RF; k++) begin
            if (!found && avail[(start + k) % NUM_RF] > 0) begin
              wb(p, (start + k) % NUM_RF, REG_WIDTH'($urandom));
              avail[(start + k) % NUM_RF]--;
              found = 1;
            end
          end
        end
      end
      bus.I_CCValue = 3'($urandom);
      if (ccPendM > 0 && $urandom_range(0, 2) == 0) bus.I_CCWEn = 1;
      if (inBranch && $urandom_range(0, 3) == 0) bus.I_WriteBackPCEn = 1;
      tick();
      total++;
      if (obsDep !== expDep) begin bad++; $display("[TB] FAIL rnd_dep cyc=%0d got=%b want=%b", c, obsDep, expDep); end
      total++;
      if (obsBr !== expBr) begin bad++; $display("[TB] FAIL rnd_br cyc=%0d got=%b want=%b", c, obsBr, expBr); end
      total++;
      if (bus.O_DE_Valid !== eValid) begin bad++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b want=%b", c, bus.O_DE_Valid, eValid); end
      total++;
      if (bus.O_PC !== ePC || bus.O_IR !== eIR) begin
        bad++; $display("[TB] FAIL rnd_pcir cyc=%0d got=%h/%h want=%h/%h", c, bus.O_PC, bus.O_IR, ePC, eIR);
      end
      total++;
      if (bus.O_Src1Value !== eS1) begin bad++; $display("[TB] FAIL rnd_src1 cyc=%0d got=%h want=%h", c, bus.O_Src1Value, eS1); end
      total++;
      if (bus.O_Src2Value !== eS2) begin bad++; $display("[TB] FAIL rnd_src2 cyc=%0d got=%h want=%h", c, bus.O_Src2Value, eS2); end
      total++;
      if (bus.O_DestRegIdx !== eDest) begin bad++; $display("[TB] FAIL rnd_dest cyc=%0d got=%0d want=%0d", c, bus.O_DestRegIdx, eDest); end
      total++;
      if (bus.O_CCValue !== eCC) begin bad++; $display("[TB] FAIL rnd_cc cyc=%0d got=%0d want=%0d", c, bus.O_CCValue, eCC); end
    end
    bus.I_GPUStallSignal = 0;
    drainAll();
  endtask

  initial begin
    test_reset();
    test_raw_forward();
    test_dual_wb();
    test_waw_sat();
    test_branch();
    test_gpu_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
